keypad_emulator: RTL



---
 rtl/keypad_emulator.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - 4x4 matrix keypad responder: holds a commanded key closed and answers row drive with column sense.
// Optional contact bounce at press/release edges is built when KEYPAD_BOUNCE_EN is defined.
module keypad_emulator #(
    parameter int HOLD_W        = 24,
    parameter int GAP_CYCLES    = 16,
    parameter int BOUNCE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        drive_in,
    output logic [3:0]        sense_out,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_key,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic              cmd_abort,
    output logic              key_active,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [HOLD_W-1:0] ONE      = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] GAP_LOAD = HOLD_W'(GAP_CYCLES);

    if (GAP_CYCLES < 1 || BOUNCE_CYCLES < 1) begin : g_bad_param
        $error("keypad_emulator: GAP_CYCLES and BOUNCE_CYCLES must be >= 1");
    end

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [3:0]        key_q, key_d;
    logic              active_q, active_d;
    logic              done_q, done_d;

`ifdef KEYPAD_BOUNCE_EN
    logic [7:0]  lfsr_q, lfsr_d;
    logic [15:0] bcnt_q, bcnt_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            key_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef KEYPAD_BOUNCE_EN
            lfsr_q   <= 8'hA5;
            bcnt_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            key_q    <= key_d;
            active_q <= active_d;
            done_q   <= done_d;
`ifdef KEYPAD_BOUNCE_EN
            lfsr_q   <= lfsr_d;
            bcnt_q   <= bcnt_d;
`endif
        end
    end

    // Exit tests use <= 1 so the counter can never wrap below zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = PRESS;
                    key_d   = cmd_key;
                    cnt_d   = (cmd_hold == '0) ? ONE : cmd_hold;
                end
            end
            PRESS: begin
                if (cnt_q <= ONE || cmd_abort) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            GAP: begin
                if (cnt_q <= ONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        done_d    = (state_q == GAP) && (state_d == IDLE);
        cmd_ready = (state_q == IDLE) && !rst;
        busy      = (state_q != IDLE);
`ifdef KEYPAD_BOUNCE_EN
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        // bcnt counts clocks already spent in the current state, saturating past the window.
        if (state_d != state_q)
            bcnt_d = '0;
        else if (bcnt_q < 16'(BOUNCE_CYCLES))
            bcnt_d = bcnt_q + 16'd1;
        else
            bcnt_d = bcnt_q;
        unique case (state_d)
            PRESS:   active_d = (bcnt_d < 16'(BOUNCE_CYCLES)) ? lfsr_d[0] : 1'b1;
            GAP:     active_d = (bcnt_d < 16'(BOUNCE_CYCLES)) ? ~lfsr_d[0] : 1'b0;
            default: active_d = 1'b0;
        endcase
`else
        active_d = (state_d == PRESS);
`endif
    end

    // Zero-latency sense so a scanner sees drive and sense as a consistent pair.
    always_comb begin
        sense_out = '0;
        for (int c = 0; c < 4; c++) begin
            sense_out[c] = active_q && !rst && drive_in[key_q[3:2]] && (key_q[1:0] == 2'(c));
        end
    end

    assign key_active = active_q;
    assign done       = done_q;

endmodule
